// File: rtl/text_column_streamer.sv
// text_column_streamer: walks the text buffer through the 8x8 column font ROM, one byte per glyph column.
// Optional TEXT_STREAM_CURSOR_EN adds cursor_on/cursor_pos to invert the glyph under the cursor.
module text_column_streamer #(
   parameter int COLS = 16,
   parameter int ROWS = 8,
   localparam int CHAR_AW = $clog2(COLS*ROWS)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [CHAR_AW-1:0] char_addr,
   input  logic [7:0]         char_data,
   output logic [10:0]        font_addr,
   input  logic [7:0]         font_data,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready
`ifdef TEXT_STREAM_CURSOR_EN
   ,
   input  logic               cursor_on,
   input  logic [CHAR_AW-1:0] cursor_pos
`endif
);
   typedef enum logic [2:0] {IDLE, RD_CHAR, WT_CHAR, RD_FONT, WT_FONT, EMIT, DONE} state_t;
   localparam logic [CHAR_AW-1:0] LAST = CHAR_AW'(COLS*ROWS-1);
   state_t state;
   logic [CHAR_AW-1:0] char_idx;
   logic [2:0] col;
   logic [7:0] char_reg;
   logic inv;
`ifdef TEXT_STREAM_CURSOR_EN
   assign inv = cursor_on && (char_idx == cursor_pos);
`else
   assign inv = 1'b0;
`endif
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         char_addr <= '0;
         font_addr <= '0;
         char_idx  <= '0;
         col       <= '0;
         char_reg  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               char_idx <= '0;
               col      <= '0;
               busy     <= 1'b1;
               state    <= RD_CHAR;
            end
            RD_CHAR: begin
               char_addr <= char_idx;
               state     <= WT_CHAR;
            end
            WT_CHAR: begin
               char_reg <= char_data;
               state    <= RD_FONT;
            end
            RD_FONT: begin
               font_addr <= {char_reg, col};
               state     <= WT_FONT;
            end
            WT_FONT: begin
               out_data  <= font_data ^ {8{inv}};
               out_valid <= 1'b1;
               state     <= EMIT;
            end
            // out_data/out_valid stay frozen until the handshake
            EMIT: if (out_ready) begin
               out_valid <= 1'b0;
               if (col != 3'd7) begin
                  col   <= col + 3'd1;
                  state <= RD_FONT;
               end else if (char_idx != LAST) begin
                  col      <= '0;
                  char_idx <= char_idx + CHAR_AW'(1);
                  state    <= RD_CHAR;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
